// File: rtl/hsv2rgb_if.sv
// Pixel stream bundle for the HSV to RGB converter: HSV pixel plus pipeline
// advance in, registered RGB pixel out.
interface hsv2rgb_if #(
  parameter int unsigned OUT_W = 8
);
  logic             EN;
  logic             I_VALID;
  logic [24:0]      H;
  logic [17:0]      S;
  logic [17:0]      V;
  logic             O_VALID;
  logic [OUT_W-1:0] R;
  logic [OUT_W-1:0] G;
  logic [OUT_W-1:0] B;

  modport master (
    output EN, I_VALID, H, S, V,
    input  O_VALID, R, G, B
  );

  modport slave (
    input  EN, I_VALID, H, S, V,
    output O_VALID, R, G, B
  );
endinterface

// File: rtl/hsv2rgb.sv
// Five-stage fixed-latency HSV to RGB converter. Every stage advances only
// while EN is high; a 5-deep valid shift register marks which outputs are real pixels.
module hsv2rgb #(
  parameter int unsigned OUT_W = 8
) (
  input logic     CLK,
  input logic     RST_N,
  hsv2rgb_if.slave bus
);

  localparam logic [24:0] HueFull = 25'h1680000;
  localparam logic [16:0] One     = 17'h10000;
  localparam int unsigned AccW    = OUT_W + 18;
  localparam logic [AccW-1:0] ChanMax = AccW'((64'd1 << OUT_W) - 64'd1);

  // Valid pipeline (reset) and output registers (reset)
  logic [3:0]       valid_d, valid_q;
  logic             o_valid_d, o_valid_q;
  logic [OUT_W-1:0] r_d, r_q, g_d, g_q, b_d, b_q;

  // Stage 1: clamped S/V, sector and residue
  logic [2:0]  k1_d, k1_q;
  logic [21:0] d1_d, d1_q;
  logic [16:0] s1_d, s1_q, v1_d, v1_q;
  // Stage 2: fractional position inside the sector
  logic [2:0]  k2_d, k2_q;
  logic [15:0] f2_d, f2_q;
  logic [16:0] s2_d, s2_q, v2_d, v2_q;
  // Stage 3: saturation-weighted terms
  logic [2:0]  k3_d, k3_q;
  logic [16:0] a3_d, a3_q, b3_d, b3_q, c3_d, c3_q, v3_d, v3_q;
  // Stage 4: value-scaled p/q/t
  logic [2:0]  k4_d, k4_q;
  logic [16:0] p4_d, p4_q, q4_d, q4_q, t4_d, t4_q, v4_d, v4_q;

  logic [24:0] h_wrap, sec_base;
  logic [16:0] f_wide, sf, fc, sfc;
  logic [16:0] r_sel, g_sel, b_sel;

  // Rounded rescale of a 1.16 fraction to a full-scale OUT_W-bit code
  function automatic logic [OUT_W-1:0] scale(input logic [16:0] x);
    return OUT_W'((AccW'(x) * ChanMax + AccW'(17'h08000)) >> 16);
  endfunction

  always_comb begin
    h_wrap = bus.H;
    if (bus.H >= HueFull) begin
      h_wrap = bus.H - HueFull;
    end
    s1_d = (bus.S > 18'h10000) ? One : bus.S[16:0];
    v1_d = (bus.V > 18'h10000) ? One : bus.V[16:0];

    k1_d     = 3'd0;
    sec_base = 25'h0;
    if (h_wrap >= 25'h12C0000) begin
      k1_d     = 3'd5;
      sec_base = 25'h12C0000;
    end else if (h_wrap >= 25'hF00000) begin
      k1_d     = 3'd4;
      sec_base = 25'hF00000;
    end else if (h_wrap >= 25'hB40000) begin
      k1_d     = 3'd3;
      sec_base = 25'hB40000;
    end else if (h_wrap >= 25'h780000) begin
      k1_d     = 3'd2;
      sec_base = 25'h780000;
    end else if (h_wrap >= 25'h3C0000) begin
      k1_d     = 3'd1;
      sec_base = 25'h3C0000;
    end
    d1_d = 22'(h_wrap - sec_base);
  end

  // 69905 / 2^22 approximates 1/60 deg scaled to a 0.16 fraction
  always_comb begin
    f_wide = 17'((39'(d1_q) * 39'd69905) >> 22);
    f2_d   = (f_wide > 17'h0FFFF) ? 16'hFFFF : f_wide[15:0];
    k2_d   = k1_q;
    s2_d   = s1_q;
    v2_d   = v1_q;
  end

  always_comb begin
    sf   = 17'((34'(s2_q) * 34'(f2_q)) >> 16);
    fc   = One - {1'b0, f2_q};
    sfc  = 17'((34'(s2_q) * 34'(fc)) >> 16);
    a3_d = One - s2_q;
    b3_d = One - sf;
    c3_d = One - sfc;
    k3_d = k2_q;
    v3_d = v2_q;
  end

  always_comb begin
    p4_d = 17'((34'(v3_q) * 34'(a3_q)) >> 16);
    q4_d = 17'((34'(v3_q) * 34'(b3_q)) >> 16);
    t4_d = 17'((34'(v3_q) * 34'(c3_q)) >> 16);
    k4_d = k3_q;
    v4_d = v3_q;
  end

  always_comb begin
    r_sel = v4_q;
    g_sel = t4_q;
    b_sel = p4_q;
    case (k4_q)
      3'd1: begin
        r_sel = q4_q;
        g_sel = v4_q;
        b_sel = p4_q;
      end
      3'd2: begin
        r_sel = p4_q;
        g_sel = v4_q;
        b_sel = t4_q;
      end
      3'd3: begin
        r_sel = p4_q;
        g_sel = q4_q;
        b_sel = v4_q;
      end
      3'd4: begin
        r_sel = t4_q;
        g_sel = p4_q;
        b_sel = v4_q;
      end
      3'd5: begin
        r_sel = v4_q;
        g_sel = p4_q;
        b_sel = q4_q;
      end
      default: begin
        r_sel = v4_q;
        g_sel = t4_q;
        b_sel = p4_q;
      end
    endcase
    r_d       = scale(r_sel);
    g_d       = scale(g_sel);
    b_d       = scale(b_sel);
    valid_d   = {valid_q[2:0], bus.I_VALID};
    o_valid_d = valid_q[3];
  end

  // Reset wins over EN so in-flight pixels are never flagged valid afterwards
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      valid_q   <= 4'b0;
      o_valid_q <= 1'b0;
      r_q       <= '0;
      g_q       <= '0;
      b_q       <= '0;
    end else if (bus.EN) begin
      valid_q   <= valid_d;
      o_valid_q <= o_valid_d;
      r_q       <= r_d;
      g_q       <= g_d;
      b_q       <= b_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (bus.EN) begin
      k1_q <= k1_d;
      d1_q <= d1_d;
      s1_q <= s1_d;
      v1_q <= v1_d;
      k2_q <= k2_d;
      f2_q <= f2_d;
      s2_q <= s2_d;
      v2_q <= v2_d;
      k3_q <= k3_d;
      a3_q <= a3_d;
      b3_q <= b3_d;
      c3_q <= c3_d;
      v3_q <= v3_d;
      k4_q <= k4_d;
      p4_q <= p4_d;
      q4_q <= q4_d;
      t4_q <= t4_d;
      v4_q <= v4_d;
    end
  end

  assign bus.O_VALID = o_valid_q;
  assign bus.R       = r_q;
  assign bus.G       = g_q;
  assign bus.B       = b_q;

endmodule

// File: tb/tb_hsv2rgb.sv
// Directed bench for hsv2rgb: hand-computed colour vectors, streaming, EN stall
// and mid-flight reset.
module tb_hsv2rgb;

  typedef struct packed {
    logic [24:0] h;
    logic [17:0] s;
    logic [17:0] v;
    logic [7:0]  r;
    logic [7:0]  g;
    logic [7:0]  b;
  } vec_t;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;
  vec_t vecs [11];

  hsv2rgb_if #(.OUT_W(8)) bus ();

  hsv2rgb #(.OUT_W(8)) u_dut (
    .CLK  (clk),
    .RST_N(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_pix(input logic [24:0] h, input logic [17:0] s, input logic [17:0] v,
                           input logic vld);
    bus.H       = h;
    bus.S       = s;
    bus.V       = v;
    bus.I_VALID = vld;
  endtask

  // Feeds vecs[first +: n] on EN-high cycles, EN low for stall_len cycles from stall_at.
  // A pixel accepted at EN-high edge a must appear after EN-high edge a+4.
  task automatic run_seq(input int first, input int n, input int stall_at, input int stall_len);
    int   e;
    int   ptr;
    int   dut_seen;
    int   exp_j;
    int   acc_edge [16];
    logic exp_v;
    logic en;
    e        = 0;
    ptr      = 0;
    dut_seen = 0;
    exp_j    = 0;
    exp_v    = 1'b0;
    for (int c = 0; c < n + stall_len + 10; c++) begin
      en     = !(c >= stall_at && c < stall_at + stall_len);
      bus.EN = en;
      if (en && ptr < n) begin
        drive_pix(vecs[first+ptr].h, vecs[first+ptr].s, vecs[first+ptr].v, 1'b1);
        acc_edge[ptr] = e + 1;
        ptr++;
      end else begin
        drive_pix(25'h1FFFFFF, 18'h0, 18'h0, 1'b0);
      end
      step();
      if (en) begin
        e++;
        exp_v = 1'b0;
        for (int j = 0; j < ptr; j++) begin
          if (acc_edge[j] + 4 == e) begin
            exp_v = 1'b1;
            exp_j = j;
          end
        end
        if (bus.O_VALID === 1'b1) dut_seen++;
      end
      check_eq($sformatf("o_valid c%0d", c), 32'(bus.O_VALID), 32'(exp_v));
      if (exp_v) begin
        check_eq($sformatf("r px%0d", first + exp_j), 32'(bus.R), 32'(vecs[first+exp_j].r));
        check_eq($sformatf("g px%0d", first + exp_j), 32'(bus.G), 32'(vecs[first+exp_j].g));
        check_eq($sformatf("b px%0d", first + exp_j), 32'(bus.B), 32'(vecs[first+exp_j].b));
      end
    end
    check_eq("pixel_count", 32'(dut_seen), 32'(n));
    bus.EN = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    vecs[0]  = '{25'h0000000, 18'h10000, 18'h10000, 8'd255, 8'd0,   8'd0};
    vecs[1]  = '{25'h0780000, 18'h10000, 18'h10000, 8'd0,   8'd255, 8'd0};
    vecs[2]  = '{25'h03C0000, 18'h10000, 18'h10000, 8'd255, 8'd255, 8'd0};
    vecs[3]  = '{25'h0123456, 18'h00000, 18'h08000, 8'd128, 8'd128, 8'd128};
    vecs[4]  = '{25'h0F00000, 18'h3FFFF, 18'h3FFFF, 8'd0,   8'd0,   8'd255};
    vecs[5]  = '{25'h1680000, 18'h10000, 18'h10000, 8'd255, 8'd0,   8'd0};
    vecs[6]  = '{25'h01E0000, 18'h10000, 18'h10000, 8'd255, 8'd127, 8'd0};
    vecs[7]  = '{25'h12C0000, 18'h10000, 18'h10000, 8'd255, 8'd0,   8'd255};
    vecs[8]  = '{25'h0F00000, 18'h08000, 18'h10000, 8'd128, 8'd128, 8'd255};
    vecs[9]  = '{25'h0B40000, 18'h10000, 18'h04000, 8'd0,   8'd64,  8'd64};
    vecs[10] = '{25'h1FFFFFF, 18'h10000, 18'h00000, 8'd0,   8'd0,   8'd0};

    // Reset with EN low must still clear the outputs
    rst_n  = 1'b0;
    bus.EN = 1'b0;
    drive_pix(25'h0, 18'h0, 18'h0, 1'b0);
    step();
    step();
    check_eq("rst o_valid", 32'(bus.O_VALID), 32'd0);
    check_eq("rst r", 32'(bus.R), 32'd0);
    check_eq("rst g", 32'(bus.G), 32'd0);
    check_eq("rst b", 32'(bus.B), 32'd0);

    rst_n  = 1'b1;
    bus.EN = 1'b1;
    run_seq(0, 1, 0, 0);
    run_seq(0, 11, 0, 0);
    run_seq(6, 5, 6, 3);

    // White pixel, then three pixels in flight when reset hits
    drive_pix(25'h0, 18'h0, 18'h10000, 1'b1);
    step();
    bus.I_VALID = 1'b0;
    step();
    step();
    step();
    drive_pix(vecs[0].h, vecs[0].s, vecs[0].v, 1'b1);
    step();
    check_eq("white o_valid", 32'(bus.O_VALID), 32'd1);
    check_eq("white r", 32'(bus.R), 32'd255);
    check_eq("white g", 32'(bus.G), 32'd255);
    check_eq("white b", 32'(bus.B), 32'd255);
    drive_pix(vecs[1].h, vecs[1].s, vecs[1].v, 1'b1);
    step();
    drive_pix(vecs[2].h, vecs[2].s, vecs[2].v, 1'b1);
    step();
    rst_n  = 1'b0;
    bus.EN = 1'b0;
    drive_pix(vecs[2].h, vecs[2].s, vecs[2].v, 1'b0);
    step();
    check_eq("midrst o_valid", 32'(bus.O_VALID), 32'd0);
    check_eq("midrst r", 32'(bus.R), 32'd0);
    check_eq("midrst g", 32'(bus.G), 32'd0);
    check_eq("midrst b", 32'(bus.B), 32'd0);
    rst_n  = 1'b1;
    bus.EN = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      check_eq($sformatf("flushed o_valid %0d", i), 32'(bus.O_VALID), 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
